sspis_wb_gasket: RTL and testbench

- Registered request/response stage between the SPI-slave Wishbone master port (sspis_top wbm_* outputs) and the system Wishbone interconnect.
- Cuts the combinational path from the SPI bridge to the fabric.
- Adds a watchdog timeout so a hung slave never locks the SPI host.
- Supplies the fixed master ID, burst-ready and burst-length sidebands.

---
 rtl/sspis_wb_pkg.sv | 18 +
 rtl/sspis_wb_gasket_if.sv | 27 ++
 rtl/sspis_wb_tmo.sv | 34 +++
 rtl/sspis_wb_gasket.sv | 132 +++++++++++++
 tb/tb_sspis_wb_gasket.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sspis_wb_pkg.sv
// sspis_wb_pkg -- shared state encoding and sideband constants for the SPI-slave Wishbone gasket.
// rev 1.0
`default_nettype none

package sspis_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [9:0]  WB_BL_SINGLE   = 10'h1;
  localparam logic [31:0] GUARD_ERR_DATA = 32'hDEAD_0000;

endpackage

`default_nettype wire

// File: rtl/sspis_wb_gasket_if.sv
// sspis_wb_gasket_if -- single-beat Wishbone request/response bundle (master drives request, slave responds).
// rev 1.0
`default_nettype none

interface sspis_wb_gasket_if;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic        we;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, adr, we, wdat, sel,
    input  rdat, ack, err
  );

  modport slave (
    input  cyc, stb, adr, we, wdat, sel,
    output rdat, ack, err
  );
endinterface

`default_nettype wire

// File: rtl/sspis_wb_tmo.sv
// sspis_wb_tmo -- clear/enable watchdog counter with terminal-count compare against TMO_CYC.
// rev 1.0
`default_nettype none

module sspis_wb_tmo #(
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 255
) (
  input  wire logic app_clk,
  input  wire logic reset,
  input  wire logic clr,
  input  wire logic en,
  output logic      tc
);

  localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TMO_CYC);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge app_clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/sspis_wb_gasket.sv
// sspis_wb_gasket -- registered Wishbone stage with watchdog between the SPI-slave bridge and the fabric.
// rev 1.0; optional address window check enabled by defining SSPIS_WB_ADDR_GUARD_EN.
`default_nettype none

module sspis_wb_gasket
  import sspis_wb_pkg::*;
#(
  parameter int         TMO_W     = 8,
  parameter int         TMO_CYC   = 255,
  parameter logic [3:0] MID       = 4'h3
`ifdef SSPIS_WB_ADDR_GUARD_EN
  ,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hF000_0000
`endif
) (
  input  wire logic          app_clk,
  input  wire logic          reset,
  sspis_wb_gasket_if.slave   s,
  sspis_wb_gasket_if.master  m,
  output logic [3:0]         m_mid_o,
  output logic               m_bry_o,
  output logic [9:0]         m_bl_o,
  output logic               tmo_flag_o,
  input  wire logic          tmo_clr_i
);

  state_t state;
  logic   tmo_hit;
  logic   req_blocked;

  assign m_mid_o = MID;
  assign m_bry_o = 1'b1;
  assign m_bl_o  = WB_BL_SINGLE;

`ifdef SSPIS_WB_ADDR_GUARD_EN
  assign req_blocked = ((s.adr & ADDR_MASK) != (ADDR_BASE & ADDR_MASK));
`else
  assign req_blocked = 1'b0;
`endif

  // Counter is held at zero while idle so every request starts a fresh watchdog window.
  sspis_wb_tmo #(
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .app_clk (app_clk),
    .reset   (reset),
    .clr     (state == ST_IDLE),
    .en      (state == ST_WAIT),
    .tc      (tmo_hit)
  );

  always_ff @(posedge app_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      m.cyc      <= 1'b0;
      m.stb      <= 1'b0;
      m.adr      <= '0;
      m.we       <= 1'b0;
      m.wdat     <= '0;
      m.sel      <= '0;
      s.rdat     <= '0;
      s.ack      <= 1'b0;
      s.err      <= 1'b0;
      tmo_flag_o <= 1'b0;
    end else begin
      s.ack <= 1'b0;
      s.err <= 1'b0;
      // A timeout later in this block overrides the clear.
      if (tmo_clr_i) begin
        tmo_flag_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (s.cyc && s.stb) begin
            if (req_blocked) begin
              s.err  <= 1'b1;
              s.rdat <= GUARD_ERR_DATA;
              state  <= ST_RESP;
            end else begin
              m.adr  <= s.adr;
              m.we   <= s.we;
              m.wdat <= s.wdat;
              m.sel  <= s.sel;
              m.cyc  <= 1'b1;
              m.stb  <= 1'b1;
              state  <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          // Slave response beats the watchdog; error beats ack.
          if (m.err) begin
            s.rdat <= m.rdat;
            s.err  <= 1'b1;
            m.cyc  <= 1'b0;
            m.stb  <= 1'b0;
            state  <= ST_RESP;
          end else if (m.ack) begin
            s.rdat <= m.rdat;
            s.ack  <= 1'b1;
            m.cyc  <= 1'b0;
            m.stb  <= 1'b0;
            state  <= ST_RESP;
          end else if (tmo_hit) begin
            s.err      <= 1'b1;
            tmo_flag_o <= 1'b1;
            m.cyc      <= 1'b0;
            m.stb      <= 1'b0;
            state      <= ST_RESP;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
          m.cyc <= 1'b0;
          m.stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sspis_wb_gasket.sv
// tb_sspis_wb_gasket -- directed self-checking bench for sspis_wb_gasket.
// rev 1.0
`default_nettype none

module tb_sspis_wb_gasket;

  logic       app_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       tmo_clr = 1'b0;
  logic [3:0] mid;
  logic       bry;
  logic [9:0] bl;
  logic       tmo_flag;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  sspis_wb_gasket_if up ();
  sspis_wb_gasket_if dn ();

  sspis_wb_gasket #(
    .TMO_W     (8),
    .TMO_CYC   (16),
    .MID       (4'h3)
`ifdef SSPIS_WB_ADDR_GUARD_EN
    ,
    .ADDR_BASE (32'h1000_0000),
    .ADDR_MASK (32'hF000_0000)
`endif
  ) dut (
    .app_clk    (app_clk),
    .reset      (reset),
    .s          (up),
    .m          (dn),
    .m_mid_o    (mid),
    .m_bry_o    (bry),
    .m_bl_o     (bl),
    .tmo_flag_o (tmo_flag),
    .tmo_clr_i  (tmo_clr)
  );

  always #5 app_clk = ~app_clk;

  task automatic tick;
    @(posedge app_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    up.cyc  = 1'b1;
    up.stb  = 1'b1;
    up.adr  = a;
    up.we   = w;
    up.wdat = d;
    up.sel  = s;
  endtask

  task automatic drop;
    up.cyc = 1'b0;
    up.stb = 1'b0;
  endtask

  initial begin
    up.cyc = 1'b0; up.stb = 1'b0; up.adr = '0; up.we = 1'b0; up.wdat = '0; up.sel = '0;
    dn.rdat = '0; dn.ack = 1'b0; dn.err = 1'b0;

    repeat (3) tick();
    chk("rst_m_cyc", 32'(dn.cyc), 32'd0);
    chk("rst_m_stb", 32'(dn.stb), 32'd0);
    chk("rst_m_adr", dn.adr, 32'd0);
    chk("rst_s_ack", 32'(up.ack), 32'd0);
    chk("rst_s_err", 32'(up.err), 32'd0);
    chk("rst_s_dat", up.rdat, 32'd0);
    chk("rst_mid", 32'(mid), 32'h3);
    chk("rst_bry", 32'(bry), 32'd1);
    chk("rst_bl", 32'(bl), 32'd1);
    chk("rst_tmo_flag", 32'(tmo_flag), 32'd0);
    reset = 1'b0;
    tick();

    // Write, slave acks three cycles after the downstream strobe
    req(32'h1000_0040, 1'b1, 32'hA5A5_1234, 4'hF);
    tick();
    chk("wr_m_cyc", 32'(dn.cyc), 32'd1);
    chk("wr_m_stb", 32'(dn.stb), 32'd1);
    chk("wr_m_adr", dn.adr, 32'h1000_0040);
    chk("wr_m_dat", dn.wdat, 32'hA5A5_1234);
    chk("wr_m_sel", 32'(dn.sel), 32'hF);
    chk("wr_m_we", 32'(dn.we), 32'd1);
    repeat (3) tick();
    chk("wr_no_early_ack", 32'(up.ack), 32'd0);
    chk("wr_m_adr_held", dn.adr, 32'h1000_0040);
    dn.ack = 1'b1;
    tick();
    chk("wr_s_ack", 32'(up.ack), 32'd1);
    chk("wr_s_err", 32'(up.err), 32'd0);
    chk("wr_m_cyc_resp", 32'(dn.cyc), 32'd0);
    dn.ack = 1'b0;
    drop();
    tick();
    chk("wr_ack_one_cycle", 32'(up.ack), 32'd0);

    // Read, slave acks immediately
    req(32'h1000_0080, 1'b0, 32'd0, 4'hF);
    tick();
    chk("rd_m_we", 32'(dn.we), 32'd0);
    dn.rdat = 32'hCAFE_F00D;
    dn.ack  = 1'b1;
    tick();
    chk("rd_s_ack", 32'(up.ack), 32'd1);
    chk("rd_s_dat", up.rdat, 32'hCAFE_F00D);
    dn.ack  = 1'b0;
    dn.rdat = 32'd0;
    drop();
    tick();
    chk("rd_ack_one_cycle", 32'(up.ack), 32'd0);
    chk("rd_s_dat_hold", up.rdat, 32'hCAFE_F00D);

    // Ack and err together: err wins
    req(32'h1000_0100, 1'b0, 32'd0, 4'hF);
    tick();
    dn.ack  = 1'b1;
    dn.err  = 1'b1;
    dn.rdat = 32'h1234_5678;
    tick();
    chk("both_s_err", 32'(up.err), 32'd1);
    chk("both_s_ack", 32'(up.ack), 32'd0);
    chk("both_s_dat", up.rdat, 32'h1234_5678);
    dn.ack = 1'b0;
    dn.err = 1'b0;
    drop();
    tick();

    // Silent slave: timeout after 16 wait cycles, clear held on the same edge (set wins)
    req(32'h1000_0200, 1'b1, 32'h0000_0001, 4'h1);
    tick();
    repeat (16) tick();
    chk("tmo_no_early_err", 32'(up.err), 32'd0);
    chk("tmo_m_cyc_waiting", 32'(dn.cyc), 32'd1);
    tmo_clr = 1'b1;
    tick();
    chk("tmo_s_err", 32'(up.err), 32'd1);
    chk("tmo_s_ack", 32'(up.ack), 32'd0);
    chk("tmo_flag_set_wins", 32'(tmo_flag), 32'd1);
    chk("tmo_m_cyc_drop", 32'(dn.cyc), 32'd0);
    tmo_clr = 1'b0;
    drop();
    dn.ack = 1'b1;
    tick();
    chk("late_ack_resp", 32'(up.ack), 32'd0);
    tick();
    chk("late_ack_idle", 32'(up.ack), 32'd0);
    chk("late_ack_m_cyc", 32'(dn.cyc), 32'd0);
    chk("tmo_flag_sticky", 32'(tmo_flag), 32'd1);
    dn.ack  = 1'b0;
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    chk("tmo_flag_clr", 32'(tmo_flag), 32'd0);

    // Ack on the terminal-count cycle: slave wins
    req(32'h1000_0204, 1'b0, 32'd0, 4'hF);
    tick();
    repeat (16) tick();
    dn.ack  = 1'b1;
    dn.rdat = 32'h5A5A_0001;
    tick();
    chk("tc_ack_s_ack", 32'(up.ack), 32'd1);
    chk("tc_ack_s_err", 32'(up.err), 32'd0);
    chk("tc_ack_flag", 32'(tmo_flag), 32'd0);
    chk("tc_ack_s_dat", up.rdat, 32'h5A5A_0001);
    dn.ack  = 1'b0;
    dn.rdat = 32'd0;
    drop();
    tick();

    // Reset while waiting, then a fresh read
    req(32'h1000_0300, 1'b0, 32'd0, 4'hF);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rstw_m_cyc", 32'(dn.cyc), 32'd0);
    chk("rstw_m_stb", 32'(dn.stb), 32'd0);
    chk("rstw_s_ack", 32'(up.ack), 32'd0);
    chk("rstw_s_err", 32'(up.err), 32'd0);
    chk("rstw_s_dat", up.rdat, 32'd0);
    drop();
    reset = 1'b0;
    tick();
    chk("rstw_idle_s_err", 32'(up.err), 32'd0);
    req(32'h1000_0304, 1'b0, 32'd0, 4'hF);
    tick();
    chk("post_rst_m_adr", dn.adr, 32'h1000_0304);
    dn.rdat = 32'h0BAD_CAFE;
    dn.ack  = 1'b1;
    tick();
    chk("post_rst_s_ack", 32'(up.ack), 32'd1);
    chk("post_rst_s_dat", up.rdat, 32'h0BAD_CAFE);
    dn.ack  = 1'b0;
    dn.rdat = 32'd0;
    drop();
    tick();

`ifdef SSPIS_WB_ADDR_GUARD_EN
    // Out-of-window request is refused without touching the fabric
    req(32'h2000_0000, 1'b0, 32'd0, 4'hF);
    tick();
    chk("guard_m_cyc", 32'(dn.cyc), 32'd0);
    chk("guard_s_err", 32'(up.err), 32'd1);
    chk("guard_s_dat", up.rdat, 32'hDEAD_0000);
    drop();
    tick();
    chk("guard_err_one_cycle", 32'(up.err), 32'd0);
    chk("guard_m_cyc_after", 32'(dn.cyc), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
